// File: rtl/ram_rd_pkg.sv
// Shared constants, FSM state type and FIFO entry type for the line-buffer read engine.
package ram_rd_pkg;

  localparam int unsigned DATA_W     = 1024;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned LEN_W      = 10;
  localparam int unsigned BUF_DEPTH  = 512;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } fifo_entry_t;

  // A burst can never be longer than the buffer itself.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH) : len;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, buffer read port and output stream of the read engine.
interface ram_stream_reader_if;
  import ram_rd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  // Read engine side.
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
    output cmd_ready, r_en, r_addr, m_valid, m_data, m_last
  );

  // Environment side: command source, line buffer and consumer.
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
    input  cmd_ready, r_en, r_addr, m_valid, m_data, m_last
  );

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry registered FIFO holding read lines until the consumer takes them.
module ram_rd_skid_fifo
  import ram_rd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fifo_entry_t      push_entry,
  input  logic             pop_ready,
  output logic             in_ready,
  output logic             out_valid,
  output fifo_entry_t      out_entry,
  output logic [CNT_W-1:0] count
);

  fifo_entry_t      head_q;
  fifo_entry_t      tail_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign pop       = out_valid & pop_ready;
  assign out_valid = (count_q != CNT_W'(0));
  assign in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign out_entry = head_q;
  assign count     = count_q;

  // Head always presents the oldest line; tail only used when two are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == CNT_W'(0)) head_q <= push_entry;
          else                      tail_q <= push_entry;
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_q <= push_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read engine: walks the line buffer read port and streams lines out with credit-based flow control.
module ram_stream_reader
  import ram_rd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ram_stream_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              issue;
  logic              credit_ok;
  logic              pop;
  logic [LEN_W-1:0]  cmd_len_c;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  logic              fifo_in_ready;
  fifo_entry_t       fifo_head;
  fifo_entry_t       push_entry;

  assign cmd_len_c = clamp_len(bus.cmd_len);
  assign pop       = fifo_valid & bus.m_ready;

  // Occupancy after this cycle's pop, counting the read whose data lands at this edge.
  assign credit_ok = (3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(pop));

  assign push_entry.data = bus.r_data;
  assign push_entry.last = inflight_last_q;

  ram_rd_skid_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q & fifo_in_ready),
    .push_entry (push_entry),
    .pop_ready  (bus.m_ready),
    .in_ready   (fifo_in_ready),
    .out_valid  (fifo_valid),
    .out_entry  (fifo_head),
    .count      (fifo_count)
  );

  // Next-state, counters and read issue.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    last_addr_d = last_addr_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_len_c != LEN_W'(0)) begin
            addr_d  = bus.cmd_addr;
            rem_d   = cmd_len_c;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          issue       = 1'b1;
          last_addr_d = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      last_addr_q     <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      last_addr_q     <= last_addr_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_W'(1));
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bus.r_en      = issue;
  assign bus.r_addr    = issue ? addr_q : last_addr_q;
  assign bus.m_valid   = fifo_valid;
  assign bus.m_data    = fifo_head.data;
  assign bus.m_last    = fifo_head.last;

endmodule
